// File: rtl/shift_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_seq_pkg
// Shared types and helpers for the shift-register sequencer.
//   state_t     : controller FSM encoding (IDLE=00, SHIFT=01, HOLD=10)
//   calc_cnt_w  : width of the job counter that spans W+N shift cycles
// ----------------------------------------------------------------------------
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  function automatic int calc_cnt_w(input int w, input int n);
    return (w + n > 1) ? $clog2(w + n) : 1;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// ----------------------------------------------------------------------------
// shift_seq_cnt
// Job cycle counter: clears to zero, counts up while enabled and parks at the
// terminal value W+N-1 so it never wraps inside a job.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (count -> 0)
//   clr_i  : load zero (start of a job)
//   en_i   : advance by one
//   cnt_o  : current count
//   tc_o   : count equals W+N-1
// ----------------------------------------------------------------------------
module shift_seq_cnt
  import shift_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = calc_cnt_w(W, N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(W + N - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for an external serial-in/serial-out shift register of depth N.
// Takes a W-bit word over a valid/ready handshake, shifts it LSB first into
// the register followed by N flush cycles, re-assembles the bits coming back
// on sr_q and offers the word on an output valid/ready handshake.
// Ports:
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    : input word handshake
//   in_data, in_dir      : word to serialize and its shift direction
//   sr_enable/sr_dir/sr_d: enable, direction and serial data to the register
//   sr_q                 : registered serial output of the register
//   out_valid/out_ready  : output word handshake
//   out_data             : re-assembled word
//   busy                 : controller is not in IDLE
// Optional build macro SHIFT_SEQ_CHECK_EN adds:
//   err                  : sticky flag, a job returned a word != the one sent
//   err_cnt              : saturating 8-bit count of mismatched jobs
// ----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_dir,
  output logic         sr_enable,
  output logic         sr_dir,
  output logic         sr_d,
  input  logic         sr_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef SHIFT_SEQ_CHECK_EN
  output logic         err,
  output logic [7:0]   err_cnt,
`endif
  output logic         busy
);

  localparam int CNT_W = calc_cnt_w(W, N);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);
  localparam logic [W-1:0]     ONE = W'(1);

  state_t           state_q;
  logic             in_ready_q, sr_enable_q, sr_dir_q, sr_d_q;
  logic             out_valid_q, busy_q;
  logic [W-1:0]     out_data_q;
  logic [W-1:0]     word_q, cap_q, cap_d;
  logic [CNT_W-1:0] cnt, nxt_cnt, cap_idx;
  logic             tc, accept, sr_d_nxt;
`ifdef SHIFT_SEQ_CHECK_EN
  logic             err_q;
  logic [7:0]       err_cnt_q;
`endif

  assign accept = (state_q == IDLE) && in_valid;

  shift_seq_cnt #(.N(N), .W(W), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == SHIFT),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  // Next serial bit: shifting past W yields zero, which supplies the flush
  // bits for free. A bit driven at cnt=i returns on sr_q during cnt=i+N.
  always_comb begin
    nxt_cnt  = cnt + 1'b1;
    sr_d_nxt = |(word_q & (ONE << nxt_cnt));
    cap_idx  = cnt - N_C;
    cap_d    = cap_q;
    if ((state_q == SHIFT) && (cnt >= N_C)) begin
      cap_d = (cap_q & ~(ONE << cap_idx)) | (W'(sr_q) << cap_idx);
    end
  end

  // Word and capture registers carry data only; cap_q is cleared per job.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= in_data;
      cap_q  <= '0;
    end else begin
      cap_q  <= cap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      sr_enable_q <= 1'b0;
      sr_dir_q    <= 1'b0;
      sr_d_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SHIFT_SEQ_CHECK_EN
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q     <= SHIFT;
            in_ready_q  <= 1'b0;
            sr_enable_q <= 1'b1;
            sr_dir_q    <= in_dir;
            sr_d_q      <= in_data[0];
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          if (tc) begin
            // cap_d already holds the bit captured on this edge.
            state_q     <= HOLD;
            sr_enable_q <= 1'b0;
            sr_d_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= cap_d;
`ifdef SHIFT_SEQ_CHECK_EN
            if (cap_d != word_q) begin
              err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
            end
`endif
          end else begin
            sr_d_q <= sr_d_nxt;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign sr_enable = sr_enable_q;
  assign sr_dir    = sr_dir_q;
  assign sr_d      = sr_d_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
`ifdef SHIFT_SEQ_CHECK_EN
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Bench for shift_seq_ctrl with N=4, W=8 and a behavioural SISO register
// (depth N, registered serial output) closing the loop on sr_d -> sr_q.
// ----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int JL = W + N;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_dir;
  logic         sr_enable, sr_dir, sr_d, sr_q;
  logic         out_valid, out_ready, busy;
  logic [W-1:0] in_data, out_data;
`ifdef SHIFT_SEQ_CHECK_EN
  logic         err;
  logic [7:0]   err_cnt;
`endif

  logic         stuck_lo = 1'b0;
  logic [N-1:0] sreg = '0;
  int           n_chk = 0;
  int           n_err = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic          dir;
    int            hold_lo;
    logic [W-1:0]  exp_data;
    logic [JL-1:0] exp_sd;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .sr_enable (sr_enable),
    .sr_dir    (sr_dir),
    .sr_d      (sr_d),
    .sr_q      (sr_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFT_SEQ_CHECK_EN
    .err       (err),
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  // SISO register model: dir=0 fills toward the top, dir=1 toward the bottom;
  // same N-edge latency either way.
  always @(posedge clk) begin
    if (sr_enable) begin
      if (sr_dir) sreg <= {sr_d, sreg[N-1:1]};
      else        sreg <= {sreg[N-2:0], sr_d};
    end
  end
  assign sr_q = stuck_lo ? 1'b0 : (sr_dir ? sreg[0] : sreg[N-1]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_sr_enable"}, sr_enable, 0);
    chk({tag, "_sr_dir"},    sr_dir,    0);
    chk({tag, "_sr_d"},      sr_d,      0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // One full job starting from IDLE; out_ready is held low for hold_lo
  // HOLD cycles, during which an in_valid pulse must be ignored.
  task automatic run_job(input vec_t v);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_dir    = v.dir;
    out_ready = (v.hold_lo == 0);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < JL; c++) begin
      chk("shift_en", sr_enable, 1);
      chk("shift_sd", sr_d, v.exp_sd[c]);
      chk("shift_dir", sr_dir, v.dir);
      chk("shift_in_ready", in_ready, 0);
      chk("shift_out_valid", out_valid, 0);
      step();
    end
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, v.exp_data);
    chk("hold_en", sr_enable, 0);
    for (int k = 0; k < v.hold_lo; k++) begin
      chk("hold_stable_valid", out_valid, 1);
      chk("hold_stable_data", out_data, v.exp_data);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
      in_valid = (k == 2);
      in_data  = 8'hFF;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_en", sr_enable, 0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'hA5, 1'b0, 0, 8'hA5, 12'h0A5};
    vecs[1] = '{8'h3C, 1'b1, 0, 8'h3C, 12'h03C};
    vecs[2] = '{8'hA5, 1'b0, 5, 8'hA5, 12'h0A5};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
`ifdef SHIFT_SEQ_CHECK_EN
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) run_job(vecs[i]);

    // Reset in the middle of SHIFT at cnt=6.
    in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("mid_sd", sr_d, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("midrst");
    step();
    chk("midrst_no_valid", out_valid, 0);
    out_ready = 1'b0;
    v = '{8'h01, 1'b0, 0, 8'h01, 12'h001};
    run_job(v);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; in_data = 8'h12; in_dir = 1'b0; out_ready = 1'b1;
    step();
    in_data = 8'hED;
    repeat (JL) step();
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_data", out_data, 8'h12);
    step();
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_idle_valid", out_valid, 0);
    step();
    chk("b2b_second_en", sr_enable, 1);
    chk("b2b_second_ready", in_ready, 0);
    chk("b2b_second_sd0", sr_d, 1);
    in_valid = 1'b0;
    repeat (JL) step();
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_data", out_data, 8'hED);
    step();
    chk("b2b_done_valid", out_valid, 0);
    out_ready = 1'b0;

`ifdef SHIFT_SEQ_CHECK_EN
    chk("chk_err_clear", err, 0);
    stuck_lo = 1'b1;
    v = '{8'h80, 1'b0, 0, 8'h00, 12'h080};
    run_job(v);
    chk("chk_err_set", err, 1);
    chk("chk_err_cnt1", err_cnt, 1);
    stuck_lo = 1'b0;
    v = '{8'h5A, 1'b1, 0, 8'h5A, 12'h05A};
    run_job(v);
    chk("chk_err_sticky", err, 1);
    chk("chk_err_cnt_hold", err_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
